mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory-access stage. Sits directly downstream of the execute stage.
- Consumes its memctrl request (valid, write, sign, size, address, write data) and runs one transaction per instruction on a single-outstanding req/ack data bus.
- Stalls the pipeline until the transaction completes.
- Loads: returns aligned, sign/zero-extended read data to writeback. ARMv4 rotated semantics apply to unaligned word loads.
- A bus that fails to acknowledge within a bounded time produces a data-abort pulse.

Parameters:
- TIMEOUT, 64, number of cycles waited for i_bus_ack before aborting. Must be ≥2.
- TW, 7, width of the timeout counter. Must satisfy 2^TW > TIMEOUT.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_memctrl_vld  input  1  access request from execute. Held stable while o_stall=1.
- i_memctrl_wr  input  1  1=store, 0=load.
- i_memctrl_sign  input  1  sign-extend load data (byte/halfword only).
- i_memctrl_size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 treated as word.
- i_memctrl_addr  input  32  byte address.
- i_memctrl_wdata  input  32  store data, right-justified.
- o_bus_req  output  1  bus request, held until ack.
- o_bus_wr  output  1  bus write.
- o_bus_addr  output  32  word-aligned address; bits [1:0] = 00.
- o_bus_be  output  4  byte enables; bit n covers wdata[8n+7:8n].
- o_bus_wdata  output  32  lane-replicated store data.
- i_bus_ack  input  1  transaction complete; read data valid in the same cycle.
- i_bus_rdata  input  32  read data.
- o_stall  output  1  freeze upstream pipeline registers.
- o_rdata_vld  output  1  one-cycle pulse: o_rdata holds a completed load result.
- o_rdata  output  32  aligned and extended load data.
- o_abort  output  1  one-cycle data-abort pulse on timeout.

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge) has priority over everything, including mid-transaction.
  - FSM returns to IDLE; timeout counter cleared.
  - o_bus_req, o_bus_wr, o_rdata_vld and o_abort are 0 from the next cycle; o_bus_addr, o_bus_be, o_bus_wdata and o_rdata are 0.
  - A pending ack arriving later is ignored.
  - While i_rst=1, o_stall=0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if i_memctrl_vld=1, capture the request into bus registers and go to WAIT. Otherwise stay in IDLE.
  - WAIT: o_bus_req=1. On i_bus_ack=1: capture load data, go to DONE. If the counter reaches TIMEOUT-1 without ack: go to DONE with the abort flag set.
  - DONE: lasts exactly one cycle, then go to IDLE unconditionally. i_memctrl_vld during DONE belongs to the completing instruction and is ignored.
- o_stall (combinational) = (IDLE && i_memctrl_vld) || WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Minimum latency: request seen in IDLE at cycle T → bus request visible T+1 → ack at T+1 → DONE at T+2. Stall is therefore 2 cycles per access.
- o_rdata_vld = DONE && load && no abort. o_abort = DONE && abort flag. Both are registered-state outputs and never high together.
- Timeout counter:
  - Cleared on entering WAIT; increments each WAIT cycle without ack.
  - An ack in the same cycle the counter hits TIMEOUT-1 counts as success, not abort.
- Store lanes:
  - Byte: be = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Halfword: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}. addr[0] is ignored.
  - Word: be = 1111; wdata unchanged.
- Load lanes (registered at ack):
  - Byte: select the lane at addr[1:0]; zero- or sign-extend per sign.
  - Halfword: select the lane at addr[1]; extend per sign.
  - Word: rdata rotated right by 8×addr[1:0] (ARMv4 unaligned LDR). sign is ignored.
- Loads drive be = 1111.
- o_bus_* outputs are held constant for the whole of WAIT. Outside WAIT, o_bus_req=0 and the other bus outputs keep their last values.

Test Plan:
- Word load, addr 0x100, ack one cycle after req, rdata 0xDEADBEEF → o_bus_addr 0x100, be 1111; stall high 2 cycles; o_rdata_vld pulse with o_rdata 0xDEADBEEF.
- Byte store, addr 0x203, wdata 0x000000A5 → o_bus_addr 0x200, be 1000, o_bus_wdata 0xA5A5A5A5, o_bus_wr=1; no o_rdata_vld pulse.
- Signed halfword load, addr 0x42, rdata 0x80010000 → o_rdata 0xFFFF8001; same access with sign=0 → 0x00008001.
- Unaligned word load, addr 0x101, rdata 0x44332211 → o_rdata 0x11443322. Signed byte load at 0x102, rdata 0x00F00000 → 0xFFFFFFF0.
- TIMEOUT=4, no ack → req high 4 cycles, then o_abort pulses for 1 cycle, o_rdata_vld stays 0, FSM returns to IDLE. Ack on the 4th WAIT cycle → success, no abort.
- i_rst pulsed during WAIT → o_bus_req 0 the next cycle, o_stall 0, no pulses. A late ack is ignored. Next request completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory-access stage: runs one single-outstanding req/ack bus transaction per
// instruction, stalls the pipeline meanwhile, and aligns/extends load data.
//
// state | meaning
// IDLE  | no transaction; accept a request from execute
// WAIT  | bus request outstanding; waiting for ack or timeout
// DONE  | one-cycle completion; load result or abort pulse presented
module mem_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memctrl_vld,
  input  logic        i_memctrl_wr,
  input  logic        i_memctrl_sign,
  input  logic [1:0]  i_memctrl_size,
  input  logic [31:0] i_memctrl_addr,
  input  logic [31:0] i_memctrl_wdata,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stall,
  output logic        o_rdata_vld,
  output logic [31:0] o_rdata,
  output logic        o_abort
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] cnt;
  logic          abort_q;
  logic [1:0]    addr_lo;
  logic [1:0]    size_q;
  logic          sign_q;

  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [63:0]   rot_dbl;
  logic [31:0]   rot;
  logic [15:0]   half;
  logic [31:0]   load_data;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = i_memctrl_wdata;
    case (i_memctrl_size)
      2'b00: begin
        be_n    = 4'b0001 << i_memctrl_addr[1:0];
        wdata_n = {4{i_memctrl_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = i_memctrl_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{i_memctrl_wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = i_memctrl_wdata;
      end
    endcase
  end

  // Rotating right by the byte offset puts the addressed byte lane in [7:0]
  // and gives the ARMv4 unaligned-word result directly.
  always_comb begin
    rot_dbl   = {i_bus_rdata, i_bus_rdata} >> {addr_lo, 3'b000};
    rot       = rot_dbl[31:0];
    half      = addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    load_data = rot;
    case (size_q)
      2'b00:   load_data = {{24{sign_q & rot[7]}}, rot[7:0]};
      2'b01:   load_data = {{16{sign_q & half[15]}}, half};
      default: load_data = rot;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      abort_q     <= 1'b0;
      addr_lo     <= 2'b00;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      o_bus_wr    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_be    <= '0;
      o_bus_wdata <= '0;
      o_rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_memctrl_vld) begin
            state       <= S_WAIT;
            cnt         <= '0;
            abort_q     <= 1'b0;
            addr_lo     <= i_memctrl_addr[1:0];
            size_q      <= i_memctrl_size;
            sign_q      <= i_memctrl_sign;
            o_bus_wr    <= i_memctrl_wr;
            o_bus_addr  <= {i_memctrl_addr[31:2], 2'b00};
            o_bus_be    <= i_memctrl_wr ? be_n : 4'b1111;
            o_bus_wdata <= wdata_n;
          end
        end
        S_WAIT: begin
          if (i_bus_ack) begin
            if (!o_bus_wr) o_rdata <= load_data;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            abort_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_bus_req   = (state == S_WAIT);
  assign o_stall     = !i_rst && (((state == S_IDLE) && i_memctrl_vld) || (state == S_WAIT));
  assign o_rdata_vld = (state == S_DONE) && !o_bus_wr && !abort_q;
  assign o_abort     = (state == S_DONE) && abort_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a short timeout so abort paths are cheap.
module tb_mem_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_memctrl_vld;
  logic        i_memctrl_wr;
  logic        i_memctrl_sign;
  logic [1:0]  i_memctrl_size;
  logic [31:0] i_memctrl_addr;
  logic [31:0] i_memctrl_wdata;
  logic        o_bus_req;
  logic        o_bus_wr;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic        o_stall;
  logic        o_rdata_vld;
  logic [31:0] o_rdata;
  logic        o_abort;

  int tests = 0;
  int fails = 0;

  mem_ctrl #(.TIMEOUT(4), .TW(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_memctrl_vld(i_memctrl_vld), .i_memctrl_wr(i_memctrl_wr),
    .i_memctrl_sign(i_memctrl_sign), .i_memctrl_size(i_memctrl_size),
    .i_memctrl_addr(i_memctrl_addr), .i_memctrl_wdata(i_memctrl_wdata),
    .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr), .o_bus_addr(o_bus_addr),
    .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .o_stall(o_stall), .o_rdata_vld(o_rdata_vld), .o_rdata(o_rdata),
    .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // d = number of ack-less WAIT cycles before the ack cycle
  task automatic access(input string tag, input logic wr, input logic sign,
                        input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int d, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    int stalls;
    stalls = 0;
    i_memctrl_vld   = 1'b1;
    i_memctrl_wr    = wr;
    i_memctrl_sign  = sign;
    i_memctrl_size  = size;
    i_memctrl_addr  = addr;
    i_memctrl_wdata = wdata;
    #1;
    if (o_stall) stalls++;
    step();
    chk({tag, ".req"}, 32'(o_bus_req), 32'd1);
    chk({tag, ".addr"}, o_bus_addr, exp_addr);
    chk({tag, ".be"}, 32'(o_bus_be), 32'(exp_be));
    chk({tag, ".wr"}, 32'(o_bus_wr), 32'(wr));
    if (wr) chk({tag, ".wdata"}, o_bus_wdata, exp_wdata);
    for (int k = 0; k < d; k++) begin
      if (o_stall) stalls++;
      step();
    end
    chk({tag, ".req_hold"}, 32'(o_bus_req), 32'd1);
    if (o_stall) stalls++;
    i_bus_ack   = 1'b1;
    i_bus_rdata = rdata;
    step();
    i_bus_ack   = 1'b0;
    i_bus_rdata = 32'h0;
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(d + 2));
    chk({tag, ".done_stall"}, 32'(o_stall), 32'd0);
    chk({tag, ".done_req"}, 32'(o_bus_req), 32'd0);
    chk({tag, ".rdata_vld"}, 32'(o_rdata_vld), 32'(!wr));
    chk({tag, ".abort"}, 32'(o_abort), 32'd0);
    if (!wr) chk({tag, ".rdata"}, o_rdata, exp_rdata);
    step();
    i_memctrl_vld = 1'b0;
    chk({tag, ".vld_after"}, 32'(o_rdata_vld), 32'd0);
    chk({tag, ".req_after"}, 32'(o_bus_req), 32'd0);
    #1;
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    i_memctrl_vld = 1'b1;
    i_memctrl_wr = 1'b0;
    i_memctrl_sign = 1'b0;
    i_memctrl_size = 2'b10;
    i_memctrl_addr = 32'h0;
    i_memctrl_wdata = 32'h0;
    i_bus_ack = 1'b0;
    i_bus_rdata = 32'h0;
    step();
    step();
    chk("rst.stall", 32'(o_stall), 32'd0);
    chk("rst.req", 32'(o_bus_req), 32'd0);
    chk("rst.wr", 32'(o_bus_wr), 32'd0);
    chk("rst.addr", o_bus_addr, 32'h0);
    chk("rst.be", 32'(o_bus_be), 32'h0);
    chk("rst.wdata", o_bus_wdata, 32'h0);
    chk("rst.rdata", o_rdata, 32'h0);
    chk("rst.pulses", {30'd0, o_rdata_vld, o_abort}, 32'd0);
    i_memctrl_vld = 1'b0;
    i_rst = 1'b0;
    step();
    chk("idle.stall", 32'(o_stall), 32'd0);

    access("ld_word", 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, 32'hDEADBEEF,
           32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    access("st_byte", 1'b1, 1'b0, 2'b00, 32'h203, 32'h000000A5, 0, 32'h0,
           32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0);
    access("ld_half_s", 1'b0, 1'b1, 2'b01, 32'h42, 32'h0, 1, 32'h80010000,
           32'h40, 4'b1111, 32'h0, 32'hFFFF8001);
    access("ld_half_u", 1'b0, 1'b0, 2'b01, 32'h42, 32'h0, 0, 32'h80010000,
           32'h40, 4'b1111, 32'h0, 32'h00008001);
    access("ld_word_rot", 1'b0, 1'b0, 2'b10, 32'h101, 32'h0, 0, 32'h44332211,
           32'h100, 4'b1111, 32'h0, 32'h11443322);
    access("ld_byte_s", 1'b0, 1'b1, 2'b00, 32'h102, 32'h0, 0, 32'h00F00000,
           32'h100, 4'b1111, 32'h0, 32'hFFFFFFF0);
    access("ld_byte_u", 1'b0, 1'b0, 2'b00, 32'h103, 32'h0, 0, 32'h80000000,
           32'h100, 4'b1111, 32'h0, 32'h00000080);
    access("st_half", 1'b1, 1'b0, 2'b01, 32'h13, 32'h1234ABCD, 0, 32'h0,
           32'h10, 4'b1100, 32'hABCDABCD, 32'h0);
    access("st_word11", 1'b1, 1'b0, 2'b11, 32'h20, 32'hCAFEF00D, 0, 32'h0,
           32'h20, 4'b1111, 32'hCAFEF00D, 32'h0);
    access("ld_ack_last", 1'b0, 1'b0, 2'b10, 32'h300, 32'h0, 3, 32'h12345678,
           32'h300, 4'b1111, 32'h0, 32'h12345678);

    // timeout: no ack at all
    i_memctrl_vld  = 1'b1;
    i_memctrl_wr   = 1'b0;
    i_memctrl_size = 2'b10;
    i_memctrl_addr = 32'h400;
    step();
    n = 0;
    while (o_bus_req && n < 20) begin
      n++;
      step();
    end
    chk("to.req_cycles", 32'(n), 32'd4);
    chk("to.abort", 32'(o_abort), 32'd1);
    chk("to.rdata_vld", 32'(o_rdata_vld), 32'd0);
    chk("to.stall", 32'(o_stall), 32'd0);
    i_memctrl_vld = 1'b0;
    step();
    chk("to.abort_end", 32'(o_abort), 32'd0);
    chk("to.idle_stall", 32'(o_stall), 32'd0);

    // reset in the middle of WAIT, then a late ack
    i_memctrl_vld  = 1'b1;
    i_memctrl_addr = 32'h500;
    step();
    step();
    chk("mr.req_before", 32'(o_bus_req), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("mr.stall_in_rst", 32'(o_stall), 32'd0);
    step();
    chk("mr.req", 32'(o_bus_req), 32'd0);
    chk("mr.stall", 32'(o_stall), 32'd0);
    chk("mr.addr", o_bus_addr, 32'h0);
    chk("mr.rdata", o_rdata, 32'h0);
    i_rst = 1'b0;
    i_memctrl_vld = 1'b0;
    i_bus_ack = 1'b1;
    i_bus_rdata = 32'hBAD0BAD0;
    step();
    i_bus_ack = 1'b0;
    chk("mr.late_pulses", {30'd0, o_rdata_vld, o_abort}, 32'd0);
    chk("mr.late_req", 32'(o_bus_req), 32'd0);
    step();
    chk("mr.late_pulses2", {30'd0, o_rdata_vld, o_abort}, 32'd0);
    chk("mr.late_rdata", o_rdata, 32'h0);

    access("after_rst", 1'b0, 1'b0, 2'b10, 32'h600, 32'h0, 0, 32'h0BADF00D,
           32'h600, 4'b1111, 32'h0, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
